wb_seg: RTL and testbench

Write-back pipeline segment. Latches the memory segment's outputs (ALU result, load data, instruction), selects the write-back value, and writes it into the 32×32 general register file it owns. It serves the decode stage's two combinational read ports and publishes the write-back triple for forwarding. It also keeps a retired-instruction counter.

---
 rtl/wb_seg.sv | 115 +++++++++++
 tb/tb_wb_seg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_seg.sv
`timescale 1ns/1ps
// wb_seg: write-back segment owning the 32x32 register file and a retired-instruction counter.
// Optional build macro WB_BYPASS_EN forwards the in-flight write-back value onto the read ports.
module wb_seg #(
  parameter logic [31:0] NOP_IR   = 32'hFFFF_FFFF,
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         ALUo_In_i,
  input  logic [31:0]         LMD_i,
  input  logic [31:0]         IR_i,
  input  logic [4:0]          ra_addr,
  input  logic [4:0]          rb_addr,
  output logic [31:0]         ra_data,
  output logic [31:0]         rb_data,
  output logic                wb_en,
  output logic [4:0]          wb_addr,
  output logic [31:0]         wb_data,
  output logic [31:0]         IR_Out,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LOAD  = 6'b100011;

  logic [31:0]         alu_q, alu_d;
  logic [31:0]         lmd_q, lmd_d;
  logic [31:0]         ir_q, ir_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic [31:0]         rf_q [32];

  logic [5:0] opcode;
  logic       is_bubble;
  logic       is_rtype;
  logic       is_imm;
  logic       is_load;
  logic [4:0] dest;

  // Segment latch shares the falling edge with the other pipeline segments.
  assign alu_d = ALUo_In_i;
  assign lmd_d = LMD_i;
  assign ir_d  = IR_i;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      alu_q <= '0;
      lmd_q <= '0;
      ir_q  <= NOP_IR;
    end else begin
      alu_q <= alu_d;
      lmd_q <= lmd_d;
      ir_q  <= ir_d;
    end
  end

  assign opcode    = ir_q[31:26];
  assign is_bubble = (ir_q == NOP_IR);
  assign is_rtype  = (opcode == OP_RTYPE);
  assign is_imm    = (opcode[5:3] == 3'b001);
  assign is_load   = (opcode == OP_LOAD);

  always_comb begin
    dest = ir_q[20:16];
    if (is_rtype) begin
      dest = ir_q[15:11];
    end
  end

  assign wb_en   = !is_bubble && (is_rtype || is_imm || is_load) && (dest != 5'd0);
  assign wb_addr = wb_en ? dest : 5'd0;
  assign wb_data = is_load ? lmd_q : alu_q;
  assign IR_Out  = ir_q;

  // Rising-edge write lands half a cycle after the latch, ahead of the next decode read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_en) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, ~is_bubble};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

  function automatic logic [31:0] read_port(input logic [4:0] addr);
    logic [31:0] val;
    val = rf_q[addr];
`ifdef WB_BYPASS_EN
    if (wb_en && (addr == wb_addr)) begin
      val = wb_data;
    end
`endif
    if (addr == 5'd0) begin
      val = '0;
    end
    return val;
  endfunction

  assign ra_data = read_port(ra_addr);
  assign rb_data = read_port(rb_addr);

endmodule

// File: tb/tb_wb_seg.sv
`timescale 1ns/1ps
// tb_wb_seg: vector table, hand-written corner sequences and random traffic against a register-file model.
module tb_wb_seg;

  localparam logic [31:0] NOP = 32'hFFFF_FFFF;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ALUo_In_i = '0;
  logic [31:0] LMD_i = '0;
  logic [31:0] IR_i = NOP;
  logic [4:0]  ra_addr = '0;
  logic [4:0]  rb_addr = '0;
  logic [31:0] ra_data, rb_data, wb_data, IR_Out, retired;
  logic        wb_en;
  logic [4:0]  wb_addr;

  always #5 clk = ~clk;

  wb_seg dut (
    .clk(clk), .rst(rst),
    .ALUo_In_i(ALUo_In_i), .LMD_i(LMD_i), .IR_i(IR_i),
    .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_data), .rb_data(rb_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .IR_Out(IR_Out), .retired(retired)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] m_rf [32];
  logic [31:0] m_ret;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] alu;
    logic [31:0] lmd;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_ret = '0;
  endtask

  // Destination register from the opcode rules; -1 when nothing is written.
  function automatic int ref_dest(input logic [31:0] ir);
    int op;
    if (ir == NOP) return -1;
    op = int'(ir >> 26);
    if (op == 0) return int'((ir >> 11) & 32'd31);
    if ((op >= 8 && op <= 15) || op == 35) return int'((ir >> 16) & 32'd31);
    return -1;
  endfunction

  function automatic logic [31:0] pre_read(input logic [4:0] a, input logic en,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return '0;
    if (BYP && en && a == wa) return wd;
    return m_rf[a];
  endfunction

  // Called just after a rising edge; returns just after the following rising edge.
  task automatic apply(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] lmd,
                       input logic exp_en, input logic [4:0] exp_addr, input logic [31:0] exp_data);
    logic [4:0] pa, pb;
    IR_i = ir;
    ALUo_In_i = alu;
    LMD_i = lmd;
    pa = 5'($urandom_range(0, 31));
    pb = exp_en ? exp_addr : 5'($urandom_range(0, 31));
    ra_addr = pa;
    rb_addr = pb;
    @(negedge clk); #1;
    chk("wb_en", {31'd0, wb_en}, {31'd0, exp_en});
    chk("wb_addr", {27'd0, wb_addr}, {27'd0, exp_addr});
    chk("wb_data", wb_data, exp_data);
    chk("IR_Out", IR_Out, ir);
    chk("ra_pre", ra_data, pre_read(pa, exp_en, exp_addr, exp_data));
    chk("rb_pre", rb_data, pre_read(pb, exp_en, exp_addr, exp_data));
    @(posedge clk); #1;
    if (exp_en) m_rf[exp_addr] = exp_data;
    if (ir != NOP) m_ret = m_ret + 1;
    chk("retired", retired, m_ret);
    chk("ra_post", ra_data, m_rf[pa]);
    chk("rb_post", rb_data, m_rf[pb]);
    $display("txn ir=%h alu=%h lmd=%h wb_en=%0d wb_addr=%0d wb_data=%h retired=%0d",
             ir, alu, lmd, wb_en, wb_addr, wb_data, retired);
  endtask

  task automatic apply_model(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] lmd);
    int d;
    logic en;
    logic [4:0] a;
    d = ref_dest(ir);
    en = (d > 0);
    a = en ? d[4:0] : 5'd0;
    apply(ir, alu, lmd, en, a, (ir[31:26] == 6'b100011) ? lmd : alu);
  endtask

  // Only valid while a bubble is latched and presented, so nothing can change.
  task automatic dump();
    for (int i = 1; i < 32; i++) begin
      ra_addr = 5'(i);
      rb_addr = 5'(32 - i);
      #1;
      chk("dump_ra", ra_data, m_rf[i]);
      chk("dump_rb", rb_data, m_rf[32 - i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, ir;
    vecs[0]  = '{32'h0022_1820, 32'h0000_0042, 32'h0,         1'b1, 5'd3,  32'h0000_0042};
    vecs[1]  = '{32'h8C05_0000, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 5'd5,  32'hDEAD_BEEF};
    vecs[2]  = '{32'hAC05_0000, 32'h0000_0020, 32'h0000_1234, 1'b0, 5'd0,  32'h0000_0020};
    vecs[3]  = '{32'h2000_0007, 32'h0000_0007, 32'h0,         1'b0, 5'd0,  32'h0000_0007};
    vecs[4]  = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0009, 1'b0, 5'd0,  32'h0000_0005};
    vecs[5]  = '{32'h3407_00FF, 32'h0000_ABCD, 32'h0,         1'b1, 5'd7,  32'h0000_ABCD};
    vecs[6]  = '{32'h0000_0020, 32'h0000_1111, 32'h0,         1'b0, 5'd0,  32'h0000_1111};
    vecs[7]  = '{32'h1085_0003, 32'h0000_2222, 32'h0,         1'b0, 5'd0,  32'h0000_2222};
    vecs[8]  = '{32'h3C0A_1234, 32'h1234_0000, 32'h0,         1'b1, 5'd10, 32'h1234_0000};
    vecs[9]  = '{32'h1C0B_0000, 32'h0000_3333, 32'h0,         1'b0, 5'd0,  32'h0000_3333};
    vecs[10] = '{32'h400C_0000, 32'h0000_4444, 32'h0,         1'b0, 5'd0,  32'h0000_4444};
    vecs[11] = '{32'h8C00_0000, 32'h0000_5555, 32'h0000_0077, 1'b0, 5'd0,  32'h0000_0077};
    vecs[12] = '{32'h0000_F820, 32'h0000_CAFE, 32'h0,         1'b1, 5'd31, 32'h0000_CAFE};
    vecs[13] = '{32'h800D_0000, 32'h0000_6666, 32'h0000_8888, 1'b0, 5'd0,  32'h0000_6666};

    model_reset();
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_IR_Out", IR_Out, NOP);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_retired", retired, 32'd0);
    dump();
    @(posedge clk); #1;
    rst = 1'b1;

    for (int k = 0; k < 14; k++) begin
      apply(vecs[k].ir, vecs[k].alu, vecs[k].lmd, vecs[k].en, vecs[k].addr, vecs[k].data);
    end
    apply(NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    dump();

    // r4 = 1, then overwrite with 0x99 and read during the write-back half cycle.
    apply(32'h2004_0001, 32'h1, 32'h0, 1'b1, 5'd4, 32'h1);
    IR_i = 32'h0000_2020;
    ALUo_In_i = 32'h99;
    LMD_i = 32'h0;
    ra_addr = 5'd4;
    rb_addr = 5'd0;
    @(negedge clk); #1;
    chk("bypass_pre", ra_data, BYP ? 32'h99 : 32'h1);
    @(posedge clk); #1;
    chk("bypass_post", ra_data, 32'h99);
    m_rf[4] = 32'h99;
    m_ret = m_ret + 1;
    chk("bypass_retired", retired, m_ret);

    for (int n = 0; n < 300; n++) begin
      r = $urandom();
      case ($urandom_range(0, 6))
        0: ir = {6'b000000, r[25:0]};
        1: ir = {3'b001, r[31:29], r[25:0]};
        2: ir = {6'b100011, r[25:0]};
        3: ir = {6'b101011, r[25:0]};
        4: ir = {r[31:26], r[25:0]};
        5: ir = NOP;
        default: ir = $urandom();
      endcase
      apply_model(ir, $urandom(), $urandom());
    end
    apply(NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    dump();

    // Reset pulled between the latch of a write to r6 and its rising-edge write.
    IR_i = 32'h0000_3020;
    ALUo_In_i = 32'h55;
    LMD_i = 32'h0;
    ra_addr = 5'd6;
    @(negedge clk); #1;
    chk("mid_wb_en", {31'd0, wb_en}, 32'd1);
    chk("mid_wb_addr", {27'd0, wb_addr}, 32'd6);
    rst = 1'b0;
    #1;
    chk("mid_IR_Out", IR_Out, NOP);
    chk("mid_wb_en_rst", {31'd0, wb_en}, 32'd0);
    chk("mid_wb_data_rst", wb_data, 32'd0);
    chk("mid_retired", retired, 32'd0);
    chk("mid_r6", ra_data, 32'd0);
    IR_i = NOP;
    @(posedge clk); #1;
    chk("mid_r6_after_edge", ra_data, 32'd0);
    chk("mid_retired_after_edge", retired, 32'd0);
    rst = 1'b1;
    model_reset();
    dump();
    apply(32'h0022_1820, 32'h0000_0042, 32'h0, 1'b1, 5'd3, 32'h0000_0042);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
